// File: rtl/io_pkg.sv
// io_pkg
// Shared constants for the pad-side I/O blocks.
//   SB_IO_PIN_TYPE         : iCE40 SB_IO PIN_TYPE for a registered input
//   SB_IO_PULLUP           : internal pull-up enable on button pads
//   DB_LIMIT_DEFAULT       : debounce length in cycles (1 ms at 12 MHz)
//   IO_BTN_WAKE_EN_DEFAULT : 1 when the build defines IO_BTN_WAKE_EN
package io_pkg;

   localparam logic [5:0] SB_IO_PIN_TYPE   = 6'b0000_00;
   localparam logic       SB_IO_PULLUP     = 1'b1;
   localparam int         DB_LIMIT_DEFAULT = 12000;
`ifdef IO_BTN_WAKE_EN
   localparam bit         IO_BTN_WAKE_EN_DEFAULT = 1'b1;
`else
   localparam bit         IO_BTN_WAKE_EN_DEFAULT = 1'b0;
`endif

endpackage

// File: rtl/io_buttons_if.sv
// io_buttons_if
// CPU-facing side of the button block.
//   wfi           : CPU is in WFI
//   clear         : write-1-to-clear strobe for event_pending
//   btn_bus       : debounced level, 1 = pressed
//   btn_rise      : one-cycle pulse on debounced press
//   event_pending : sticky press flags
//   wake          : wake request to the core
// master = CPU / bus side, slave = io_buttons.
interface io_buttons_if #(parameter int WIDTH = 8);

   logic             wfi;
   logic [WIDTH-1:0] clear;
   logic [WIDTH-1:0] btn_bus;
   logic [WIDTH-1:0] btn_rise;
   logic [WIDTH-1:0] event_pending;
   logic             wake;

   modport master (
      output wfi, clear,
      input  btn_bus, btn_rise, event_pending, wake
   );

   modport slave (
      input  wfi, clear,
      output btn_bus, btn_rise, event_pending, wake
   );

endinterface

// File: rtl/io_debounce.sv
// io_debounce
// One button bit: active-low synchronised sample -> debouncer -> rise
// pulse and sticky pending flag.
//   clk, reset : system clock, synchronous active-high reset
//   s1         : synchronised pad level (active-low)
//   clear      : write-1-to-clear strobe for pending
//   stable     : debounced level, 1 = pressed
//   rise       : one-cycle pulse when stable goes 0->1
//   pending    : sticky press flag
module io_debounce
   import io_pkg::*;
#(
   parameter int DB_LIMIT = DB_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic s1,
   input  logic clear,
   output logic stable,
   output logic rise,
   output logic pending
);

   localparam int               CNT_W  = $clog2(DB_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_LIMIT - 1);

   logic             raw;
   logic [CNT_W-1:0] cnt;
   logic             go_high;

   assign raw     = ~s1;
   // stable accepts a press on this edge
   assign go_high = raw & ~stable & (cnt == CNT_TC);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         stable  <= 1'b0;
         rise    <= 1'b0;
         pending <= 1'b0;
      end else begin
         rise <= go_high;

         // any sample matching the current level restarts the run
         if (raw == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            stable <= raw;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // a new press beats a simultaneous clear
         if (go_high) begin
            pending <= 1'b1;
         end else if (clear) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/io_buttons.sv
// io_buttons
// Samples WIDTH active-low button pads, synchronises and debounces each
// bit and presents clean levels, rise pulses and sticky event flags to
// the CPU. Sampling continues while the CPU is in WFI.
//   clk     : system clock, also clocks the pad input registers
//   reset   : synchronous, active-high
//   btn_pad : package pins, active-low, pull-up enabled
//   bus     : io_buttons_if.slave (wfi, clear, btn_bus, btn_rise,
//             event_pending, wake)
// Macros:
//   IO_BTN_WAKE_EN : when defined, wake <= wfi & |event_pending;
//                    otherwise wake is constant 0 and wfi is ignored.
//   ICE40_SB_IO    : when defined, the first pad stage is an SB_IO
//                    primitive; otherwise an equivalent flop.
module io_buttons
   import io_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DB_LIMIT = DB_LIMIT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn_pad,
   io_buttons_if.slave      bus
);

   logic [WIDTH-1:0] s0;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] stable_v;
   logic [WIDTH-1:0] rise_v;
   logic [WIDTH-1:0] pending_v;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
`ifdef ICE40_SB_IO
         SB_IO #(
            .PIN_TYPE (SB_IO_PIN_TYPE),
            .PULLUP   (SB_IO_PULLUP)
         ) u_pad (
            .PACKAGE_PIN (btn_pad[i]),
            .INPUT_CLK   (clk),
            .D_IN_0      (s0[i])
         );
`else
         // behavioural stand-in for the SB_IO input register; resets to
         // the released level so a reset also discards in-flight samples
         always_ff @(posedge clk) begin
            if (reset) s0[i] <= 1'b1;
            else       s0[i] <= btn_pad[i];
         end
`endif

         io_debounce #(
            .DB_LIMIT (DB_LIMIT)
         ) u_db (
            .clk     (clk),
            .reset   (reset),
            .s1      (s1[i]),
            .clear   (bus.clear[i]),
            .stable  (stable_v[i]),
            .rise    (rise_v[i]),
            .pending (pending_v[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) s1 <= '1;
      else       s1 <= s0;
   end

   assign bus.btn_bus       = stable_v;
   assign bus.btn_rise      = rise_v;
   assign bus.event_pending = pending_v;

`ifdef IO_BTN_WAKE_EN
   logic wake_q;

   always_ff @(posedge clk) begin
      if (reset) wake_q <= 1'b0;
      else       wake_q <= bus.wfi & (|pending_v);
   end

   assign bus.wake = wake_q;
`else
   logic unused_wfi;
   assign unused_wfi = bus.wfi;
   assign bus.wake   = 1'b0;
`endif

endmodule

// File: tb/tb_io_buttons.sv
module tb_io_buttons;

   localparam int W  = 8;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] btn_pad;

   io_buttons_if #(.WIDTH(W)) bus ();

   io_buttons #(.WIDTH(W), .DB_LIMIT(DB)) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_pad (btn_pad),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] lvl;
      logic [W-1:0] rise;
      logic [W-1:0] pend;
      logic         wake;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   wake_en;

   // ---------------- reference model ----------------
   // A bit's debounced level follows the pressed value once the last DB
   // samples seen by the debouncer all agree on it. The debouncer sees
   // the pad two edges late (pad register + sync register).
   logic [W-1:0] m_s0, m_s1, m_lvl, m_pend;
   logic         m_wake;
   logic [W-1:0] hist[DB];

   initial begin
      exp_t         e;
      logic [W-1:0] raw, nl, rs;
      logic         all_same;
      m_s0 = '1; m_s1 = '1; m_lvl = '0; m_pend = '0; m_wake = 1'b0;
      for (int k = 0; k < DB; k++) hist[k] = '0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_s0 = '1; m_s1 = '1; m_lvl = '0; m_pend = '0; m_wake = 1'b0;
            for (int k = 0; k < DB; k++) hist[k] = '0;
            rs = '0;
         end else begin
            raw = ~m_s1;
            for (int k = DB - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = raw;
            nl = m_lvl;
            for (int b = 0; b < W; b++) begin
               all_same = 1'b1;
               for (int k = 1; k < DB; k++)
                  if (hist[k][b] != hist[0][b]) all_same = 1'b0;
               if (all_same && hist[0][b] != m_lvl[b]) nl[b] = hist[0][b];
            end
            rs     = nl & ~m_lvl;
            m_wake = wake_en & bus.wfi & (|m_pend);
            m_pend = rs | (m_pend & ~bus.clear);
            m_lvl  = nl;
            m_s1   = m_s0;
            m_s0   = btn_pad;
         end
         e.lvl = m_lvl; e.rise = rs; e.pend = m_pend; e.wake = m_wake;
         q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got none required one entry", $time);
         end else begin
            e = q.pop_front();
            if (bus.btn_bus !== e.lvl || bus.btn_rise !== e.rise ||
                bus.event_pending !== e.pend || bus.wake !== e.wake) begin
               errors++;
               $display("FAIL outputs t=%0t got bus=%h rise=%h pend=%h wake=%b required bus=%h rise=%h pend=%h wake=%b",
                        $time, bus.btn_bus, bus.btn_rise, bus.event_pending, bus.wake,
                        e.lvl, e.rise, e.pend, e.wake);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [W-1:0] pad, input logic [W-1:0] clr,
                       input logic rst, input logic w);
      @(negedge clk);
      btn_pad   = pad;
      bus.clear = clr;
      reset     = rst;
      bus.wfi   = w;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0t got %h required %h", name, $time, act, req);
      end
   endtask

   initial begin
      logic [W-1:0] pad, clr;
      logic         w, rst;
`ifdef IO_BTN_WAKE_EN
      wake_en = 1'b1;
`else
      wake_en = 1'b0;
`endif
      btn_pad = '1; bus.clear = '0; bus.wfi = 1'b0; reset = 1'b1;

      // reset for two edges, pads released
      step('1, '0, 1'b1, 1'b0);
      step('1, '0, 1'b0, 1'b0);
      step('1, '0, 1'b0, 1'b0);
      chk("reset_bus", bus.btn_bus, 8'h00);
      chk("reset_pend", bus.event_pending, 8'h00);

      // clean press on bit 0: step k drives the level seen at edge Ek
      for (int k = 0; k < 8; k++) begin
         step(8'hfe, '0, 1'b0, 1'b0);
         if (k == 5) chk("press0_before_E5", bus.btn_bus, 8'h00);
         if (k == 6) chk("press0_after_E5", bus.btn_bus, 8'h01);
      end
      for (int k = 0; k < 8; k++) step(8'hff, '0, 1'b0, 1'b0);
      chk("release0_bus", bus.btn_bus, 8'h00);
      chk("release0_pend", bus.event_pending, 8'h01);

      // bounce on bit 2 shorter than the debounce window
      for (int k = 0; k < 3; k++) step(8'hfb, '0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) step(8'hff, '0, 1'b0, 1'b0);
      chk("bounce2_pend", bus.event_pending, 8'h01);

      // clear of bits 0,1 on the same edge as bit 1's rise
      for (int k = 0; k < 8; k++)
         step(8'hfd, (k == 5) ? 8'h03 : 8'h00, 1'b0, 1'b0);
      chk("collision_pend", bus.event_pending, 8'h02);
      for (int k = 0; k < 6; k++) step(8'hff, '0, 1'b0, 1'b0);
      step(8'hff, 8'hff, 1'b0, 1'b0);
      step(8'hff, '0, 1'b0, 1'b0);

      // wake on bit 3 press while in WFI
      for (int k = 0; k < 8; k++) begin
         step(8'hf7, '0, 1'b0, 1'b1);
         if (k == 6) chk("wake_before_E6", {7'd0, bus.wake}, 8'h00);
         if (k == 7) chk("wake_after_E6", {7'd0, bus.wake}, {7'd0, wake_en});
      end
      step(8'hf7, 8'h08, 1'b0, 1'b1);
      step(8'hf7, '0, 1'b0, 1'b1);
      chk("wake_clear_pend", bus.event_pending, 8'h00);
      step(8'hf7, '0, 1'b0, 1'b1);
      chk("wake_cleared", {7'd0, bus.wake}, 8'h00);
      for (int k = 0; k < 8; k++) step(8'hff, '0, 1'b0, 1'b0);

      // reset mid-debounce on bit 5
      for (int k = 0; k < 14; k++) begin
         step(8'hdf, '0, (k == 3), 1'b0);
         if (k == 9)  chk("rst_mid_before", bus.btn_bus, 8'h00);
         if (k == 10) chk("rst_mid_after", bus.btn_bus, 8'h20);
      end
      for (int k = 0; k < 8; k++) step(8'hff, 8'hff, 1'b0, 1'b0);

      // randomised traffic
      pad = '1; w = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 9) == 0) pad[b] = ~pad[b];
         clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         if ($urandom_range(0, 19) == 0) w = ~w;
         rst = ($urandom_range(0, 399) == 0);
         step(pad, clr, rst, w);
      end

      step('1, '0, 1'b0, 1'b0);
      step('1, '0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
